// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer owning HI/LO; fixed-latency busy and pipeline stall request.
// Optional macro MDU_MADD_EN adds madd/maddu accumulate into {hi,lo}.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] t_hi;
    logic [31:0] t_lo;
    logic        commit_en;
`ifdef MDU_MADD_EN
    logic        acc;
`endif

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] b_safe;
    logic        div_ovf;
    logic        is_mul;
    logic        is_div;
    logic [63:0] res;

    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};
        // Zero and INT_MIN/-1 divisors are replaced by 1: the former never
        // commits, and a/1 gives exactly the wrapped overflow result.
        div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        b_safe  = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
        q_s = $signed(a) / $signed(b_safe);
        r_s = $signed(a) % $signed(b_safe);
        q_u = a / b_safe;
        r_u = a % b_safe;
    end

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (op == 3'd6) || (op == 3'd7);
`endif
        is_div = (op == OP_DIV) || (op == OP_DIVU);
    end

    always_comb begin
        res = 64'd0;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = {r_s, q_s};
            OP_DIVU:  res = {r_u, q_u};
`ifdef MDU_MADD_EN
            3'd6:     res = prod_s;
            3'd7:     res = prod_u;
`endif
            default:  res = 64'd0;
        endcase
    end

    assign stall_req = md_use_d & (busy | (start & (is_mul | is_div)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            t_hi      <= 32'd0;
            t_lo      <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            busy      <= 1'b0;
            commit_en <= 1'b0;
`ifdef MDU_MADD_EN
            acc       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul || is_div) begin
                            {t_hi, t_lo} <= res;
                            cnt          <= is_mul ? MUL_LOAD : DIV_LOAD;
                            commit_en    <= is_mul || (b != 32'd0);
                            busy         <= 1'b1;
                            state        <= RUN;
`ifdef MDU_MADD_EN
                            acc          <= op[2];
`endif
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (commit_en) begin
`ifdef MDU_MADD_EN
                            // Accumulate onto HI/LO as they stand now.
                            {hi, lo} <= acc ? ({hi, lo} + {t_hi, t_lo})
                                            : {t_hi, t_lo};
`else
                            {hi, lo} <= {t_hi, t_lo};
`endif
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: latency, arithmetic, mthi/mtlo, stall and reset abort.
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    md_unit_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .md_use_d  (md_use_d),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op at a negedge, then count busy cycles (bounded) and stall hits.
    task automatic run_op(input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input bit inject,
                          output int n, output int st);
        n  = 0;
        st = 0;
        start = 1'b1; op = o; a = va; b = vb; md_use_d = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            if (stall_req) st++;
            if (inject && n == 2) begin
                start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        md_use_d = 1'b0;
    endtask

    int n;
    int st;

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0;
        a = 32'd0; b = 32'd0; md_use_d = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        md_use_d = 1'b1;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);

        // mult: stall must already be up in the start cycle
        start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFB; b = 32'd3;
        #1;
        chk("mult_stall_start", {31'd0, stall_req}, 32'd1);
        start = 1'b0;
        run_op(3'd0, 32'hFFFF_FFFB, 32'd3, 1'b0, n, st);
        chk("mult_cycles", n, 32'd5);
        chk("mult_stall_busy", st, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, n, st);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // div with a second start injected mid-run that must be ignored
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, n, st);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        repeat (8) @(negedge clk);
        chk("ign_busy", {31'd0, busy}, 32'd0);
        chk("ign_hi", hi, 32'hFFFF_FFFF);
        chk("ign_lo", lo, 32'hFFFF_FFFD);

        run_op(3'd3, 32'd7, 32'd0, 1'b0, n, st);
        chk("divz_cycles", n, 32'd10);
        chk("divz_hi", hi, 32'hFFFF_FFFF);
        chk("divz_lo", lo, 32'hFFFF_FFFD);

        // mthi / mtlo: no busy, no stall
        md_use_d = 1'b1;
        start = 1'b1; op = 3'd4; a = 32'h1234_5678;
        #1;
        chk("mthi_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo", lo, 32'hFFFF_FFFD);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; op = 3'd5; a = 32'hCAFE_BABE;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", lo, 32'hCAFE_BABE);
        chk("mtlo_hi", hi, 32'h1234_5678);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n, st);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, n, st);
        chk("smin_hi", hi, 32'h4000_0000);
        chk("smin_lo", lo, 32'd0);

        run_op(3'd3, 32'd100, 32'd7, 1'b0, n, st);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

`ifndef MDU_MADD_EN
        md_use_d = 1'b1;
        start = 1'b1; op = 3'd6; a = 32'd2; b = 32'd3;
        #1;
        chk("madd_off_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("madd_off_busy", {31'd0, busy}, 32'd0);
        chk("madd_off_lo", lo, 32'd14);
        md_use_d = 1'b0;
`endif

        // reset abort at busy cycle 4
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) n++;
            if (n == 4) break;
            @(negedge clk);
        end
        chk("abort_reach", n, 32'd4);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multiply/divide unit with its own sequencer; sits in the EX stage beside the ALU and owns the HI/LO registers.
- Accepts one operation per start pulse and holds busy for a fixed latency.
- Produces a stall request that the hazard logic ORs into the pipeline stall: freeze PC and IF/ID, flush ID/EX.
- Serves mult, multu, div, divu, mthi, mtlo; HI/LO are read combinationally by mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  EX-stage instruction is a valid md op this cycle (single-cycle pulse per instruction).
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
- a  in  32  forwarded rs value from EX.
- b  in  32  forwarded rt value from EX.
- md_use_d  in  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo (or madd/maddu).
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  operation in flight.
- stall_req  out  1  stall request to the pipeline.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: hi=0, lo=0, busy=0, state IDLE, counter=0, result temps=0. Reset asserted mid-operation aborts it; no HI/LO commit.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; 4-bit counter cnt.
- IDLE with start:
  - op 0..3: latch the 64-bit result into temp {t_hi,t_lo} at the start edge from a,b. Load cnt=MULT_CYCLES or DIV_CYCLES, go to RUN.
  - op 4 (mthi): hi<=a at the start edge; lo unchanged; stays IDLE; busy never asserted.
  - op 5 (mtlo): lo<=a at the start edge; hi unchanged; stays IDLE; busy never asserted.
- RUN:
  - cnt decrements every edge.
  - On the edge where cnt==1: {hi,lo}<={t_hi,t_lo}, go to IDLE.
  - Net effect: busy is high for exactly N cycles, starting the cycle after start; the new HI/LO are visible the cycle busy falls.
- start while RUN: ignored, with no effect on state, temps or HI/LO. The pipeline guarantees this cannot happen, because stall_req holds the instruction in D.
- Arithmetic:
  - mult: signed 32x32 -> 64, HI=upper, LO=lower.
  - multu: unsigned 32x32 -> 64.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - b==0 for div/divu: still runs DIV_CYCLES with busy; HI/LO unchanged at commit.
- stall_req = md_use_d & (busy | (start & op<=3)). It also covers the start cycle itself, so the D-stage instruction never observes stale HI/LO.
- mfhi/mflo reading hi/lo in the same cycle as an mthi/mtlo start sees the old value. The pipeline forwards that case itself; this block does not.
- hi, lo and busy are registered outputs; stall_req is combinational.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 6 (madd): {hi,lo} += signed product of a,b.
  - op 7 (maddu): {hi,lo} += unsigned product of a,b.
  - Both are 64-bit wrap-around accumulations with MULT_CYCLES latency and included in stall_req.
  - The accumulation uses {hi,lo} as of the commit edge.
- Not defined: op 6/7 with start is a no-op: no busy, HI/LO unchanged, stall_req ignores it.

Test Plan:
- Reset: hold reset 2 cycles, release -> hi=0, lo=0, busy=0, stall_req=0.
- mult: start op=0, a=0xFFFFFFFB, b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1. md_use_d=1 during busy -> stall_req=1 on all 6 cycles (start + 5).
- multu: op=1, a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- div signed/unsigned:
  - op=2, a=0xFFFFFFF9, b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - op=3, a=7, b=0 -> busy 10 cycles, hi/lo unchanged.
- mthi/mtlo and ignored start:
  - op=4, a=0x12345678 -> hi=0x12345678 next cycle, busy stays 0.
  - A second start asserted during RUN is ignored and its result never appears.
- Reset mid-op: start op=2 with a=100, b=7, assert reset at busy cycle 4 -> busy=0, hi=lo=0 next cycle, no later commit.
